// File: rtl/mask_pkg.sv
// mask_pkg: shared types and constants for the mask erosion stage.
//   erode_state_t : frame sequencing states (FILL, RUN, FLUSH)
//   MASK_FG/BG    : output byte values for foreground / background
//   is_fg()       : classifies an incoming mask byte as foreground
package mask_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } erode_state_t;

  localparam logic [7:0] MASK_FG = 8'hFF;
  localparam logic [7:0] MASK_BG = 8'h00;

  // Any nonzero mask byte counts as foreground.
  function automatic logic is_fg(input logic [7:0] pix);
    return |pix;
  endfunction

endpackage

// File: rtl/mask_line_buffer.sv
// mask_line_buffer: 1-bit, WIDTH-deep circular row store.
// Read and write share one column address; the read is combinational, so the
// value seen during a write cycle is the old contents (read-before-write).
//   clock : rising-edge clock
//   addr  : column address (0..WIDTH-1)
//   wr_en : write wdata at addr on this edge
//   wdata : bit to store
//   rdata : bit currently stored at addr
module mask_line_buffer #(
  parameter int WIDTH = 720,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic          clock,
  input  logic [AW-1:0] addr,
  input  logic          wr_en,
  input  logic          wdata,
  output logic          rdata
);

  // No reset: stale bits only ever land on border outputs, which are forced 0.
  logic [WIDTH-1:0] mem;

  assign rdata = mem[addr];

  always_ff @(posedge clock) begin
    if (wr_en) mem[addr] <= wdata;
  end

endmodule

// File: rtl/mask_erode.sv
// mask_erode: streaming 3x3 binary erosion between two FWFT FIFOs.
// Pops mask bytes in raster order, emits one eroded byte (FF/00) per pixel in
// the same order, delayed by WIDTH+1 pixels (output for pop (r,c) is the
// center pixel (r-1,c-1)). Image border pixels are always 00.
//   clock, reset       : rising-edge clock, async active-low reset
//   in_empty, in_dout  : upstream FIFO status / head byte
//   in_rd_en           : pop upstream this cycle
//   out_full           : downstream FIFO full
//   out_din, out_wr_en : eroded byte / push this cycle
import mask_pkg::*;

module mask_erode #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_empty,
  input  logic [7:0] in_dout,
  output logic       in_rd_en,
  input  logic       out_full,
  output logic [7:0] out_din,
  output logic       out_wr_en
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int NW = $clog2(WIDTH + 2);

  localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(HEIGHT - 1);
  // FILL and FLUSH each span WIDTH+1 transfers: counter runs 0..WIDTH.
  localparam logic [NW-1:0] PHASE_LAST = NW'(WIDTH);

  erode_state_t state, state_nxt;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [NW-1:0] cnt;

  // Window columns, bit 2 = row r-2, bit 1 = row r-1, bit 0 = row r.
  // win_c2 holds column c-2, win_c1 column c-1, win_c0 is the incoming column.
  logic [2:0] win_c2, win_c1, win_c0;
  logic       lb0_rd, lb1_rd, fg;
  logic       last_px, phase_done, core;

  assign fg         = is_fg(in_dout);
  assign win_c0     = {lb1_rd, lb0_rd, fg};
  assign last_px    = (row == ROW_LAST) && (col == COL_LAST);
  assign phase_done = (cnt == PHASE_LAST);

  // Center (r-1,c-1) is interior exactly when r>=2 and c>=2 (r-1<=HEIGHT-2
  // and c-1<=WIDTH-2 always hold). For c<2 the window straddles two rows,
  // but those outputs are border pixels and are forced to background.
  assign core = (row >= RW'(2)) && (col >= CW'(2)) && (&{win_c2, win_c1, win_c0});

  // Line buffer 0 holds row r-1, line buffer 1 holds row r-2. Writing the
  // old lb0 bit into lb1 at the same column rolls both rows down by one.
  mask_line_buffer #(.WIDTH(WIDTH), .AW(CW)) u_lb0 (
    .clock (clock),
    .addr  (col),
    .wr_en (in_rd_en),
    .wdata (fg),
    .rdata (lb0_rd)
  );

  mask_line_buffer #(.WIDTH(WIDTH), .AW(CW)) u_lb1 (
    .clock (clock),
    .addr  (col),
    .wr_en (in_rd_en),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  always_comb begin
    state_nxt = state;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    out_din   = MASK_BG;
    unique case (state)
      FILL: begin
        // Gated with reset so nothing is popped while reset is held.
        in_rd_en = reset && !in_empty;
        if (in_rd_en && phase_done) state_nxt = RUN;
      end
      RUN: begin
        // Pop and push are locked together: one in, one out.
        in_rd_en  = !in_empty && !out_full;
        out_wr_en = in_rd_en;
        out_din   = core ? MASK_FG : MASK_BG;
        if (in_rd_en && last_px) state_nxt = FLUSH;
      end
      FLUSH: begin
        // Remaining outputs are (HEIGHT-2,WIDTH-1) and row HEIGHT-1: all border.
        out_wr_en = !out_full;
        if (out_wr_en && phase_done) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= FILL;
      col    <= '0;
      row    <= '0;
      cnt    <= '0;
      win_c2 <= '0;
      win_c1 <= '0;
    end else begin
      state <= state_nxt;

      if (in_rd_en) begin
        win_c2 <= win_c1;
        win_c1 <= win_c0;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end

      // Shared FILL/FLUSH transfer counter; idle (zero) during RUN.
      unique case (state)
        FILL:    if (in_rd_en)  cnt <= phase_done ? '0 : cnt + NW'(1);
        FLUSH:   if (out_wr_en) cnt <= phase_done ? '0 : cnt + NW'(1);
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: doc/mask_erode.md
# mask_erode

Streaming 3x3 binary erosion stage that sits directly downstream of the background-subtraction block. It pops 8-bit mask pixels from the subtract output FIFO in raster order and outputs a de-speckled mask to the next FIFO, one byte per pixel, in the same order. Isolated foreground noise is removed before the mask is reconstructed into a 3-byte BMP pixel. Line storage is 1 bit per pixel, so two image rows cost 2×WIDTH flops or one small RAM.

## Interface
- WIDTH, 720, image width in pixels (≥3)
- HEIGHT, 540, image height in pixels (≥3)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- in_empty  in  1  upstream FWFT FIFO empty
- in_dout  in  8  upstream mask pixel, valid while in_empty=0
- in_rd_en  out  1  pop upstream FIFO this cycle
- out_full  in  1  downstream FIFO full
- out_din  out  8  eroded pixel, 8'hFF or 8'h00
- out_wr_en  out  1  push out_din this cycle

## Operation
- Input classification: a pixel is foreground when in_dout != 0. The bit is stored as 1 in the window and line buffers.
- Input position counters: col in 0..WIDTH-1 and row in 0..HEIGHT-1, advanced on each pop. col wraps to 0 and increments row. At row=HEIGHT-1, col=WIDTH-1 the counters return to 0/0.
- Window: a 3x3 bit array whose rows are line buffer 1 (row r-2), line buffer 0 (row r-1), and the current input (row r). Columns are c-2, c-1, and the incoming c. On a pop the window shifts left and the new column is inserted. Line buffer 0 takes the new bit; line buffer 1 takes line buffer 0's old bit at the same column.
- Output for input k=(r,c) is the center pixel (r-1,c-1):
  - 8'hFF if 1≤r-1≤HEIGHT-2, 1≤c-1≤WIDTH-2, and all 9 window bits are 1.
  - 8'h00 otherwise. All image border pixels are therefore 8'h00.
- FSM states:
  - FILL: pop whenever in_empty=0; no output. After WIDTH+1 pops, go to RUN.
  - RUN: in_rd_en = out_wr_en = !in_empty && !out_full, so one pop produces one push. When the pop of the last pixel (HEIGHT-1, WIDTH-1) occurs, go to FLUSH.
  - FLUSH: in_rd_en=0. Push 8'h00 whenever !out_full, WIDTH+1 times; these are pixel (HEIGHT-2, WIDTH-1) and all of row HEIGHT-1. Then go to FILL for the next frame.
- Each frame produces exactly WIDTH×HEIGHT outputs, in raster order.
- Stale line-buffer or window contents from a previous frame or from before reset reach only border positions, where the output is forced to 0. No clearing is required.

## Timing
- Reset (asynchronous, active-low):
  - state=FILL; counters and the FILL/FLUSH counter = 0.
  - While reset is low or in FILL: in_rd_en=0 unless popping, out_wr_en=0, out_din=8'h00.
- in_rd_en, out_wr_en and out_din are combinational from the registered state, the window, in_dout, in_empty and out_full. The pixel is transferred in the same cycle; there is no added latency beyond the WIDTH+1-pixel window lag.
- The window, line buffers and counters update on the rising edge at which in_rd_en=1.
- In RUN, a push never happens without a pop and a pop never happens without a push. With both FIFOs always ready the block sustains 1 pixel/cycle.
- If in_empty and out_full toggle together, the transfer waits until both are clear. Nothing is dropped or duplicated.
- Reset mid-frame: the partial frame is abandoned and the next popped pixel is treated as (0,0).

## Structure
- Package mask_pkg holds:
  - typedef enum {FILL, RUN, FLUSH} erode_state_t
  - localparams MASK_FG=8'hFF and MASK_BG=8'h00
- Sub-module mask_line_buffer: a 1-bit, WIDTH-deep circular buffer with read-before-write at a shared column address. It is instantiated twice.
- The FSM, counters, window and erosion AND live in mask_erode.

## Test plan
All scenarios use WIDTH=8, HEIGHT=6.
- All-0xFF frame with FIFOs always ready -> 48 outputs; the 24 interior pixels (rows 1–4, cols 1–6) are 0xFF and the 24 border pixels are 0x00; throughput is 1 pixel/cycle after 9 fill pops.
- All-0xFF frame except a 0x00 at (3,3) -> outputs at rows 2–4, cols 2–4 are 0x00; the other interior pixels are 0xFF.
- Single 0xFF pixel at (2,2) in a zero frame -> all 48 outputs are 0x00.
- All-0x01 frame -> identical to the all-0xFF result (nonzero counts as foreground).
- Random in_empty and out_full stalls (about 30% each) on the scenario-1 frame -> identical 48-byte stream; no push without a pop in RUN; exactly 48 pushes.
- Reset asserted after 20 pops, then two back-to-back all-0xFF frames -> outputs go to 0 asynchronously; each frame produces exactly 48 correct outputs; the second frame starts in FILL with no extra or missing bytes.
